// File: rtl/sdf_delay_line_if.sv
// Sample-stream bundle between an SDF butterfly stage and its feedback delay line.
// The data width follows the parameter of the line it serves.
interface sdf_delay_line_if #(
  parameter int WIDTH = 24
);
  logic                    flush;
  logic                    in_valid;
  logic signed [WIDTH-1:0] din_r;
  logic signed [WIDTH-1:0] din_i;
  logic signed [WIDTH-1:0] dout_r;
  logic signed [WIDTH-1:0] dout_i;
  logic                    dout_valid;
  logic                    busy;

  modport master (
    output flush, in_valid, din_r, din_i,
    input  dout_r, dout_i, dout_valid, busy
  );

  modport slave (
    input  flush, in_valid, din_r, din_i,
    output dout_r, dout_i, dout_valid, busy
  );
endinterface

// File: rtl/sdf_delay_line.sv
// Complex (re/im) delay line with a valid bit per slot for the SDF feedback paths.
// After a burst it drains itself with invalid zeros; flush clears it synchronously.
module sdf_delay_line #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  sdf_delay_line_if.slave  bus
);

  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                  state_r;
  logic [CW-1:0]           drain_cnt_r;
  logic                    busy_r;
  logic signed [WIDTH-1:0] re_r [DEPTH];
  logic signed [WIDTH-1:0] im_r [DEPTH];
  logic [DEPTH-1:0]        v_r;
  logic                    shift_en_s;

  // The line only moves on a real sample or while draining; idle cycles hold it.
  assign shift_en_s = bus.in_valid | (state_r == DRAIN);

  // Slot storage: slot 0 takes the new sample or an invalid zero, the rest shift down.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        re_r[k] <= {WIDTH{1'b0}};
        im_r[k] <= {WIDTH{1'b0}};
      end
      v_r <= {DEPTH{1'b0}};
    end else if (bus.flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        re_r[k] <= {WIDTH{1'b0}};
        im_r[k] <= {WIDTH{1'b0}};
      end
      v_r <= {DEPTH{1'b0}};
    end else if (shift_en_s) begin
      if (bus.in_valid) begin
        re_r[0] <= bus.din_r;
        im_r[0] <= bus.din_i;
        v_r[0]  <= 1'b1;
      end else begin
        re_r[0] <= {WIDTH{1'b0}};
        im_r[0] <= {WIDTH{1'b0}};
        v_r[0]  <= 1'b0;
      end
      for (int k = 1; k < DEPTH; k++) begin
        re_r[k] <= re_r[k-1];
        im_r[k] <= im_r[k-1];
        v_r[k]  <= v_r[k-1];
      end
    end else begin
      v_r <= v_r;
    end
  end

  // Burst control: the first idle cycle after a burst only arms the drain; the
  // drain then makes exactly DEPTH invalid shifts so every stored sample leaves.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      drain_cnt_r <= {CW{1'b0}};
      busy_r      <= 1'b0;
    end else if (bus.flush) begin
      state_r     <= IDLE;
      drain_cnt_r <= {CW{1'b0}};
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            state_r <= RUN;
            busy_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        RUN: begin
          if (bus.in_valid) begin
            state_r <= RUN;
          end else begin
            state_r     <= DRAIN;
            drain_cnt_r <= CW'(DEPTH);
          end
          busy_r <= 1'b1;
        end
        DRAIN: begin
          if (bus.in_valid) begin
            state_r     <= RUN;
            drain_cnt_r <= {CW{1'b0}};
            busy_r      <= 1'b1;
          end else if (drain_cnt_r == CW'(1)) begin
            state_r     <= IDLE;
            drain_cnt_r <= {CW{1'b0}};
            busy_r      <= 1'b0;
          end else begin
            drain_cnt_r <= drain_cnt_r - CW'(1);
            busy_r      <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          drain_cnt_r <= {CW{1'b0}};
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dout_r     = re_r[DEPTH-1];
  assign bus.dout_i     = im_r[DEPTH-1];
  assign bus.dout_valid = v_r[DEPTH-1];
  assign bus.busy       = busy_r;

endmodule
